// File: rtl/intersection_pkg.sv
// Shared phase/state types and the phase-to-lamp decode for the intersection controller.
package intersection_pkg;

    typedef enum logic [1:0] {
        PH_STRAIGHT = 2'd0,
        PH_TURN     = 2'd1,
        PH_PED      = 2'd2
    } phase_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_GREEN = 1'b1
    } state_t;

    // Lamp vector ordering: {pedestrian, up, down, turn}
    function automatic logic [3:0] phase_greens(input phase_t ph);
        case (ph)
            PH_STRAIGHT: return 4'b0110;
            PH_TURN:     return 4'b0101;
            PH_PED:      return 4'b1000;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/phase_rr_pick.sv
// Round-robin selection of the next pending phase after the current one.
module phase_rr_pick
    import intersection_pkg::*;
(
    input  phase_t     cur_phase,
    input  logic [2:0] pending,
    output phase_t     next_phase,
    output logic       other_valid
);

    phase_t p1, p2;
    logic   hit1, hit2;

    always_comb begin
        case (cur_phase)
            PH_STRAIGHT: begin p1 = PH_TURN;     p2 = PH_PED;      end
            PH_TURN:     begin p1 = PH_PED;      p2 = PH_STRAIGHT; end
            default:     begin p1 = PH_STRAIGHT; p2 = PH_TURN;     end
        endcase
        hit1        = |(pending & (3'b001 << p1));
        hit2        = |(pending & (3'b001 << p2));
        other_valid = hit1 | hit2;
        next_phase  = hit1 ? p1 : (hit2 ? p2 : cur_phase);
    end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase controller: one green phase at a time, min/max green and all-red clearance.
module phase_scheduler
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = $clog2(MAX_GREEN + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up_car,
    input  logic       down_car,
    input  logic       turn_car,
    input  logic       ped_button,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       pedestrian_green,
    output logic [1:0] active_phase,
    output logic       clearing
);

    state_t           state;
    phase_t           cur_phase;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       pending;

    phase_t     next_phase;
    logic       other_valid;
    logic [2:0] presence, cur_onehot, green_mask, pending_nxt;
    logic       in_green, own_present, enter_green, exit_green;

    phase_rr_pick u_pick (
        .cur_phase   (cur_phase),
        .pending     (pending),
        .next_phase  (next_phase),
        .other_valid (other_valid)
    );

    always_comb begin
        presence    = {ped_button, turn_car, up_car | down_car};
        in_green    = (state == ST_GREEN);
        cur_onehot  = 3'b001 << cur_phase;
        green_mask  = in_green ? cur_onehot : 3'b000;
        own_present = |(presence & cur_onehot);
        enter_green = (state == ST_CLEAR) && (cnt == CNT_W'(CLEAR_CYCLES - 1));
        exit_green  = in_green && (cnt >= CNT_W'(MIN_GREEN - 1)) && other_valid &&
                      (!own_present || (cnt == CNT_W'(MAX_GREEN - 1)));
        // Entering a phase consumes its request even if it is still asserted this cycle
        pending_nxt = (pending | (presence & ~green_mask)) &
                      ~(enter_green ? cur_onehot : 3'b000);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            cur_phase <= PH_STRAIGHT;
            cnt       <= '0;
            pending   <= '0;
        end else if (cur_phase > PH_PED) begin
            state     <= ST_CLEAR;
            cur_phase <= PH_STRAIGHT;
            cnt       <= '0;
            pending   <= '0;
        end else begin
            pending <= pending_nxt;
            case (state)
                ST_CLEAR: begin
                    if (enter_green) begin
                        state <= ST_GREEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GREEN: begin
                    if (exit_green) begin
                        state     <= ST_CLEAR;
                        cnt       <= '0;
                        cur_phase <= next_phase;
                    end else if (cnt != CNT_W'(MAX_GREEN - 1)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    cur_phase <= PH_STRAIGHT;
                    cnt       <= '0;
                    pending   <= '0;
                end
            endcase
        end
    end

    assign {pedestrian_green, up_green, down_green, turn_green} =
        in_green ? phase_greens(cur_phase) : 4'b0000;
    assign active_phase = cur_phase;
    assign clearing     = ~in_green;

endmodule
